// File: rtl/chrono_pkg.sv
// chrono_pkg: shared state encoding, BCD digit geometry and display field
// offsets for the stopwatch controller.
package chrono_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_LAP    = 2'd3
    } state_t;

    localparam int DIG_W   = 4;
    localparam int NUM_DIG = 6;
    localparam int MOD_DEC = 10;
    localparam int MOD_SEX = 6;

    // Digit positions inside the packed {min_t,min_o,sec_t,sec_o,cs_t,cs_o} word
    localparam int OFF_CS_O  = 0;
    localparam int OFF_CS_T  = 4;
    localparam int OFF_SEC_O = 8;
    localparam int OFF_SEC_T = 12;
    localparam int OFF_MIN_O = 16;
    localparam int OFF_MIN_T = 20;

    // Packed BCD value of the full count MAX_MIN:59.99
    function automatic logic [NUM_DIG*DIG_W-1:0] full_count(input int unsigned max_min);
        full_count = {4'(max_min / 10), 4'(max_min % 10), 4'd5, 4'd9, 4'd9, 4'd9};
    endfunction

endpackage

// File: rtl/chrono_ctrl_bcd_digit.sv
// bcd_digit: one BCD counter digit with synchronous clear and ripple carry.
// The carry is combinational so a whole carry chain settles within one tick.
module bcd_digit
    import chrono_pkg::*;
#(
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [DIG_W-1:0] q,
    output logic             carry
);

    localparam logic [DIG_W-1:0] Q_MAX = DIG_W'(MODULUS - 1);

    // Count on enable, roll over at the top value; clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= (q == Q_MAX) ? '0 : q + 1'b1;
    end

    assign carry = en & (q == Q_MAX);

endmodule

// File: rtl/chrono_ctrl.sv
// chrono_ctrl: stopwatch sequencer owning the MM:SS.cc BCD counters and the
// prescaler clear. Define CHRONO_LAP_EN to build the LAP state and its
// display snapshot; otherwise btn_lap is ignored and the display is live.
module chrono_ctrl
    import chrono_pkg::*;
#(
    parameter int MAX_MIN    = 59,
    parameter int SAT_ON_OVF = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        btn_ss,
    input  logic        btn_clr,
    input  logic        btn_lap,
    output logic        presc_clr,
    output logic        running,
    output logic        ovf,
    output logic [23:0] disp_bcd
);

    localparam logic [23:0] FULL = full_count(MAX_MIN);

    state_t                         state, nxt;
    logic [NUM_DIG-1:0][DIG_W-1:0]  dig;
    logic [NUM_DIG-1:0]             dig_en, dig_cy;
    logic [23:0]                    live;
    logic                           win_clr, win_ss;
    logic                           counting, at_full, ovf_evt, inc, clr_cnt;
    logic                           top_cy_unused;

    // Button priority: clear beats start/stop beats lap
    assign win_clr = btn_clr;
    assign win_ss  = btn_ss & ~btn_clr;

`ifdef CHRONO_LAP_EN
    logic win_lap;
    assign win_lap = btn_lap & ~btn_ss & ~btn_clr;
`else
    logic lap_unused;
    assign lap_unused = btn_lap;
`endif

    assign counting = (state == ST_RUN) || (state == ST_LAP);
    assign at_full  = (live == FULL);
    assign ovf_evt  = counting & tick & at_full;
    // At full count the whole chain is held off, which also keeps the
    // minute digits from counting past MAX_MIN.
    assign inc      = counting & tick & ~at_full;
    assign clr_cnt  = ((state == ST_PAUSED) & win_clr) | (ovf_evt & (SAT_ON_OVF == 0));

    // Carry chain: each digit advances on the carry of the one below
    assign dig_en[0] = inc;
    for (genvar i = 1; i < NUM_DIG; i++) begin : g_chain
        assign dig_en[i] = dig_cy[i-1];
    end

    for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
        bcd_digit #(
            .MODULUS((i * DIG_W == OFF_SEC_T) ? MOD_SEX : MOD_DEC)
        ) u_dig (
            .clk   (clk),
            .rst   (rst),
            .en    (dig_en[i]),
            .clr   (clr_cnt),
            .q     (dig[i]),
            .carry (dig_cy[i])
        );
    end

    assign top_cy_unused = dig_cy[NUM_DIG-1];

    assign live[OFF_CS_O  +: DIG_W] = dig[0];
    assign live[OFF_CS_T  +: DIG_W] = dig[1];
    assign live[OFF_SEC_O +: DIG_W] = dig[2];
    assign live[OFF_SEC_T +: DIG_W] = dig[3];
    assign live[OFF_MIN_O +: DIG_W] = dig[4];
    assign live[OFF_MIN_T +: DIG_W] = dig[5];

    // Next-state decode; a saturating overflow overrides any button move
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:   if (win_ss) nxt = ST_RUN;
            ST_RUN: begin
                if (win_ss) nxt = ST_PAUSED;
`ifdef CHRONO_LAP_EN
                else if (win_lap) nxt = ST_LAP;
`endif
            end
            ST_PAUSED: begin
                if (win_clr)     nxt = ST_IDLE;
                else if (win_ss) nxt = ST_RUN;
            end
`ifdef CHRONO_LAP_EN
            ST_LAP: begin
                if (win_lap)     nxt = ST_RUN;
                else if (win_ss) nxt = ST_PAUSED;
            end
`endif
            default:   nxt = ST_IDLE;
        endcase
        if (ovf_evt && (SAT_ON_OVF != 0))
            nxt = ST_PAUSED;
    end

    // State register with outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            running   <= 1'b0;
            presc_clr <= 1'b1;
            ovf       <= 1'b0;
        end else begin
            state     <= nxt;
            running   <= (nxt == ST_RUN) || (nxt == ST_LAP);
            presc_clr <= !((nxt == ST_RUN) || (nxt == ST_LAP));
            if ((state == ST_PAUSED) && win_clr)
                ovf <= 1'b0;
            else if (ovf_evt)
                ovf <= 1'b1;
        end
    end

`ifdef CHRONO_LAP_EN
    logic [23:0] snap;

    // Freeze the pre-tick live value on the edge that enters LAP
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            snap <= '0;
        else if ((state == ST_RUN) && (nxt == ST_LAP))
            snap <= live;
    end

    assign disp_bcd = (state == ST_LAP) ? snap : live;
`else
    assign disp_bcd = live;
`endif

endmodule

// File: tb/tb_chrono_ctrl.sv
// tb_chrono_ctrl: three stopwatch instances (default, short saturating,
// short wrapping) driven with shared stimulus and checked every cycle
// against a centisecond-count reference model.
module tb_chrono_ctrl;

`ifdef CHRONO_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_LAP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0, btn_ss = 1'b0, btn_clr = 1'b0, btn_lap = 1'b0;

    logic        presc [3];
    logic        run   [3];
    logic        ovf   [3];
    logic [23:0] disp  [3];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state per instance
    int mst [3];
    int mcnt[3];
    int msnap[3];
    bit movf[3];
    int mfull[3] = '{59*6000 + 5999, 1*6000 + 5999, 5999};
    bit msat [3] = '{1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    chrono_ctrl #(.MAX_MIN(59), .SAT_ON_OVF(1)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .btn_ss(btn_ss), .btn_clr(btn_clr),
        .btn_lap(btn_lap), .presc_clr(presc[0]), .running(run[0]), .ovf(ovf[0]),
        .disp_bcd(disp[0]));

    chrono_ctrl #(.MAX_MIN(1), .SAT_ON_OVF(1)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .btn_ss(btn_ss), .btn_clr(btn_clr),
        .btn_lap(btn_lap), .presc_clr(presc[1]), .running(run[1]), .ovf(ovf[1]),
        .disp_bcd(disp[1]));

    chrono_ctrl #(.MAX_MIN(0), .SAT_ON_OVF(0)) dut_c (
        .clk(clk), .rst(rst), .tick(tick), .btn_ss(btn_ss), .btn_clr(btn_clr),
        .btn_lap(btn_lap), .presc_clr(presc[2]), .running(run[2]), .ovf(ovf[2]),
        .disp_bcd(disp[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int v);
        int m, s, c;
        m = v / 6000;
        s = (v / 100) % 60;
        c = v % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic mreset();
        for (int d = 0; d < 3; d++) begin
            mst[d] = S_IDLE; mcnt[d] = 0; msnap[d] = 0; movf[d] = 1'b0;
        end
    endtask

    task automatic mstep(input int d, input bit t, input bit s, input bit c, input bit l);
        int st, nst, pre;
        bit wc, ws, wl;
        st  = mst[d];
        nst = st;
        pre = mcnt[d];
        wc  = c;
        ws  = s && !c;
        wl  = l && !s && !c && LAP_EN;
        case (st)
            S_IDLE:   if (ws) nst = S_RUN;
            S_RUN:    if (ws) nst = S_PAUSED;
                      else if (wl) begin nst = S_LAP; msnap[d] = pre; end
            S_PAUSED: if (wc) begin nst = S_IDLE; mcnt[d] = 0; movf[d] = 1'b0; end
                      else if (ws) nst = S_RUN;
            default:  if (wl) nst = S_RUN;
                      else if (ws) nst = S_PAUSED;
        endcase
        if ((st == S_RUN || st == S_LAP) && t) begin
            if (pre == mfull[d]) begin
                movf[d] = 1'b1;
                if (msat[d]) nst = S_PAUSED;
                else mcnt[d] = 0;
            end else begin
                mcnt[d] = pre + 1;
            end
        end
        mst[d] = nst;
    endtask

    task automatic check_all();
        bit r;
        for (int d = 0; d < 3; d++) begin
            r = (mst[d] == S_RUN) || (mst[d] == S_LAP);
            chk($sformatf("disp%0d", d), disp[d], to_bcd(mst[d] == S_LAP ? msnap[d] : mcnt[d]));
            chk($sformatf("running%0d", d), run[d], r);
            chk($sformatf("presc_clr%0d", d), presc[d], !r);
            chk($sformatf("ovf%0d", d), ovf[d], movf[d]);
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check after it
    task automatic step(input bit t, input bit s, input bit c, input bit l);
        tick = t; btn_ss = s; btn_clr = c; btn_lap = l;
        @(posedge clk);
        for (int d = 0; d < 3; d++) mstep(d, t, s, c, l);
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick = 1'b0; btn_ss = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
        @(posedge clk);
        #1;
        mreset();
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        bit t, s, c, l;
        int r;
        mreset();
        @(posedge clk);
        do_reset();
        chk("rst_presc", presc[0], 1'b1);
        chk("rst_disp", disp[0], 24'h0);

        // start, 150 ticks
        step(0, 1, 0, 0);
        ticks(150);
        chk("run150_disp", disp[0], 24'h000150);
        chk("run150_running", run[0], 1'b1);
        chk("run150_presc", presc[0], 1'b0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);

        // pause ignores ticks, clear returns to idle
        step(0, 1, 0, 0);
        ticks(37);
        step(0, 1, 0, 0);
        ticks(20);
        chk("pause_hold", disp[0], 24'h000037);
        step(0, 0, 1, 0);
        chk("clr_disp", disp[0], 24'h0);
        chk("clr_running", run[0], 1'b0);
        chk("clr_presc", presc[0], 1'b1);

        // cascaded carry, wrap and saturation
        step(0, 1, 0, 0);
        ticks(5999);
        chk("pre_carry", disp[0], 24'h005999);
        chk("c_full", disp[2], 24'h005999);
        ticks(1);
        chk("carry_min", disp[0], 24'h010000);
        chk("c_wrap", disp[2], 24'h0);
        chk("c_wrap_ovf", ovf[2], 1'b1);
        chk("c_wrap_run", run[2], 1'b1);
        ticks(5999);
        chk("b_full", disp[1], 24'h015999);
        ticks(1);
        chk("b_sat_disp", disp[1], 24'h015999);
        chk("b_sat_ovf", ovf[1], 1'b1);
        chk("b_sat_run", run[1], 1'b0);
        chk("b_sat_presc", presc[1], 1'b1);
        chk("a_2min", disp[0], 24'h020000);

        // simultaneous start/stop and clear while paused: clear wins
        do_reset();
        step(0, 1, 0, 0);
        ticks(5);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        chk("ssclr_disp", disp[0], 24'h0);
        chk("ssclr_running", run[0], 1'b0);
        chk("ssclr_presc", presc[0], 1'b1);

        // lap freeze and release
        step(0, 1, 0, 0);
        ticks(212);
        chk("lap_pre", disp[0], 24'h000212);
        step(0, 0, 0, 1);
        ticks(100);
`ifdef CHRONO_LAP_EN
        chk("lap_frozen", disp[0], 24'h000212);
`else
        chk("nolap_live", disp[0], 24'h000312);
`endif
        step(0, 0, 0, 1);
        chk("lap_live", disp[0], 24'h000312);
        step(0, 0, 0, 1);
        ticks(3);

        // asynchronous reset between edges with tick high
        tick = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("arst_disp%0d", d), disp[d], 24'h0);
            chk($sformatf("arst_run%0d", d), run[d], 1'b0);
            chk($sformatf("arst_presc%0d", d), presc[d], 1'b1);
            chk($sformatf("arst_ovf%0d", d), ovf[d], 1'b0);
        end
        @(posedge clk);
        #1;
        mreset();
        check_all();
        rst = 1'b0;
        tick = 1'b0;

        // randomized traffic, at most one button per cycle
        repeat (4000) begin
            t = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 99));
            s = (r < 4);
            c = (r >= 4 && r < 7);
            l = (r >= 7 && r < 10);
            step(t, s, c, l);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
